// File: rtl/wallace_mult_pipe.sv
// Two-stage pipelined Wallace-tree unsigned multiplier with valid/ready handshake and tag.
// Optional sticky output (OR of low product bits) enabled by defining WALLACE_STICKY_EN.
module wallace_mult_pipe #(
   parameter int A_W      = 24,
   parameter int B_W      = 26,
   parameter int TAG_W    = 5,
   parameter int STICKY_W = 24
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [A_W-1:0]       a,
   input  logic [B_W-1:0]       b,
   input  logic [TAG_W-1:0]     in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [A_W+B_W-1:0]   z,
`ifdef WALLACE_STICKY_EN
   output logic                 sticky,
`endif
   output logic [TAG_W-1:0]     out_tag
);

   localparam int P = A_W + B_W;

   // Each 3:2 level turns every group of three rows into two; leftovers pass through.
   function automatic int tree_levels(input int r);
      int n;
      int l;
      n = r;
      l = 0;
      while (n > 2) begin
         n = n - n / 3;
         l = l + 1;
      end
      return l;
   endfunction

   localparam int LEVELS = tree_levels(B_W);

   logic [P-1:0]     rows [B_W];
   logic [P-1:0]     nxt  [B_W];
   logic [P-1:0]     tree_sum, tree_carry;
   int               n_rows, m_rows;

   logic             s1_valid_q, s1_valid_d;
   logic [P-1:0]     s1_sum_q, s1_carry_q;
   logic [TAG_W-1:0] s1_tag_q;
   logic             out_valid_q, out_valid_d;
   logic [P-1:0]     z_q, z_next;
   logic [TAG_W-1:0] out_tag_q;
   logic             s1_adv, s2_adv;

   always_comb begin
      rows   = '{default: '0};
      nxt    = '{default: '0};
      m_rows = 0;
      for (int j = 0; j < B_W; j++) begin
         rows[j] = P'(a & {A_W{b[j]}}) << j;
      end
      n_rows = B_W;
      for (int l = 0; l < LEVELS; l++) begin
         nxt    = '{default: '0};
         m_rows = 0;
         for (int i = 0; i < B_W; i += 3) begin
            if (i + 2 < n_rows) begin
               nxt[m_rows]     = rows[i] ^ rows[i+1] ^ rows[i+2];
               nxt[m_rows + 1] = ((rows[i] & rows[i+1]) | (rows[i] & rows[i+2]) |
                                  (rows[i+1] & rows[i+2])) << 1;
               m_rows          = m_rows + 2;
            end else if (i < n_rows) begin
               nxt[m_rows] = rows[i];
               m_rows      = m_rows + 1;
               if (i + 1 < n_rows) begin
                  nxt[m_rows] = rows[i+1];
                  m_rows      = m_rows + 1;
               end
            end
         end
         rows   = nxt;
         n_rows = m_rows;
      end
      tree_sum   = rows[0];
      tree_carry = (n_rows > 1) ? rows[1] : '0;
   end

   // Handshake: a stage advances when its successor is empty or draining this cycle.
   assign s2_adv      = !out_valid_q || out_ready;
   assign s1_adv      = !s1_valid_q || s2_adv;
   assign in_ready    = s1_adv;
   assign s1_valid_d  = s1_adv ? in_valid : s1_valid_q;
   assign out_valid_d = s2_adv ? s1_valid_q : out_valid_q;
   assign z_next      = s1_sum_q + s1_carry_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_sum_q   <= '0;
         s1_carry_q <= '0;
         s1_tag_q   <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         if (s1_adv && in_valid) begin
            s1_sum_q   <= tree_sum;
            s1_carry_q <= tree_carry;
            s1_tag_q   <= in_tag;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         z_q         <= '0;
         out_tag_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         if (s2_adv && s1_valid_q) begin
            z_q       <= z_next;
            out_tag_q <= s1_tag_q;
         end
      end
   end

`ifdef WALLACE_STICKY_EN
   logic sticky_q;

   // Taken from the resolved sum so it always agrees with z.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sticky_q <= 1'b0;
      end else if (s2_adv && s1_valid_q) begin
         sticky_q <= |z_next[STICKY_W-1:0];
      end
   end

   assign sticky = sticky_q;
`else
`endif

   assign out_valid = out_valid_q;
   assign z         = z_q;
   assign out_tag   = out_tag_q;

endmodule
